dcache_ctrl: RTL and testbench

Data-cache controller sitting between the CPU load/store port, the data-cache SRAM array and main memory. Drives the SRAM's read/write/fill strobes, detects misses, writes back dirty victims and refills blocks from memory over a request/ready handshake. Stalls the CPU until each access completes. Write-back, write-allocate, blocking (one outstanding miss).

---
 rtl/dcache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Blocking write-back / write-allocate data-cache controller: hit path, dirty-victim write-back, block refill.
// Optional event counters are built when DCACHE_CTRL_PERF_EN is defined; otherwise the perf ports read 0.
module dcache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 32,
  parameter int BLOCK_BITS  = BLOCK_BYTES * 8,
  parameter int OFFSET_W    = $clog2(BLOCK_BYTES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_ren,
  input  logic                         cpu_wen,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [31:0]                  cpu_wdata,
  input  logic [3:0]                   cpu_byteen,
  output logic [31:0]                  cpu_rdata,
  output logic                         cpu_stall,
  output logic                         sram_ren,
  output logic                         sram_wen,
  output logic                         sram_memWen,
  output logic [BLOCK_BYTES-1:0]       sram_bytesAccess,
  output logic [ADDR_W-OFFSET_W-1:0]   sram_blockAddr,
  output logic [BLOCK_BITS-1:0]        sram_dataIn,
  input  logic                         sram_hit,
  input  logic                         sram_dirtyBit,
  input  logic [BLOCK_BITS-1:0]        sram_dataOut,
  input  logic [ADDR_W-OFFSET_W-1:0]   sram_victimBlockAddr,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-OFFSET_W-1:0]   mem_addr,
  output logic [BLOCK_BITS-1:0]        mem_wdata,
  input  logic                         mem_ready,
  input  logic [BLOCK_BITS-1:0]        mem_rdata,
  output logic [31:0]                  perf_hits,
  output logic [31:0]                  perf_misses,
  output logic [31:0]                  perf_wbs
);

  localparam int BA_W  = ADDR_W - OFFSET_W;
  localparam int WORDS = BLOCK_BYTES / 4;

  typedef enum logic [1:0] {IDLE, WB, FILL, REFILL} state_t;

  state_t                state_q, state_d;
  logic [BA_W-1:0]       req_addr_q, req_addr_d;
  logic [BA_W-1:0]       victim_addr_q, victim_addr_d;
  // One block buffer serves both as the write-back victim and the refill data.
  logic [BLOCK_BITS-1:0] buf_q, buf_d;

  logic [OFFSET_W-1:0]   byte_off;
  logic                  req;
  logic                  hit_evt, miss_evt, wb_evt;

  always_comb begin
    byte_off         = cpu_addr[OFFSET_W-1:0] & ~OFFSET_W'(3);
    req              = cpu_ren | cpu_wen;
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    victim_addr_d    = victim_addr_q;
    buf_d            = buf_q;
    cpu_stall        = 1'b1;
    sram_ren         = 1'b0;
    sram_wen         = 1'b0;
    sram_memWen      = 1'b0;
    sram_bytesAccess = '0;
    sram_blockAddr   = cpu_addr[ADDR_W-1:OFFSET_W];
    sram_dataIn      = {WORDS{cpu_wdata}};
    cpu_rdata        = sram_dataOut[{byte_off, 3'b000} +: 32];
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = req_addr_q;
    mem_wdata        = buf_q;
    hit_evt          = 1'b0;
    miss_evt         = 1'b0;
    wb_evt           = 1'b0;

    case (state_q)
      IDLE: begin
        sram_ren  = cpu_ren & ~cpu_wen;
        sram_wen  = cpu_wen;
        if (cpu_wen) sram_bytesAccess = BLOCK_BYTES'(cpu_byteen) << byte_off;
        cpu_stall = req & ~sram_hit;
        hit_evt   = req & sram_hit;
        miss_evt  = req & ~sram_hit;
        wb_evt    = miss_evt & sram_dirtyBit;
        if (miss_evt) begin
          req_addr_d = cpu_addr[ADDR_W-1:OFFSET_W];
          if (sram_dirtyBit) begin
            buf_d         = sram_dataOut;
            victim_addr_d = sram_victimBlockAddr;
            state_d       = WB;
          end else begin
            state_d = FILL;
          end
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = victim_addr_q;
        if (mem_ready) state_d = FILL;
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          buf_d   = mem_rdata;
          state_d = REFILL;
        end
      end
      default: begin
        sram_memWen    = 1'b1;
        sram_dataIn    = buf_q;
        sram_blockAddr = req_addr_q;
        state_d        = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      victim_addr_q <= '0;
      buf_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      victim_addr_q <= victim_addr_d;
      buf_q         <= buf_d;
    end
  end

`ifdef DCACHE_CTRL_PERF_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;

  always_comb begin
    hits_d   = hits_q + 32'(hit_evt);
    misses_d = misses_q + 32'(miss_evt);
    wbs_d    = wbs_q + 32'(wb_evt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
  assign perf_wbs    = wbs_q;
`else
  logic unused_evt;
  assign unused_evt  = hit_evt ^ miss_evt ^ wb_evt;
  assign perf_hits   = '0;
  assign perf_misses = '0;
  assign perf_wbs    = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a one-entry SRAM model and a fixed-latency memory responder.
module tb_dcache_ctrl;
  localparam int ADDR_W = 32, BB = 32, BITS = 256, OW = 5, BA_W = ADDR_W - OW;
`ifdef DCACHE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 0, rst = 1;
  logic cpu_ren = 0, cpu_wen = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [3:0] cpu_byteen = 0;
  logic [31:0] cpu_rdata;
  logic cpu_stall, sram_ren, sram_wen, sram_memWen;
  logic [BB-1:0] sram_bytesAccess;
  logic [BA_W-1:0] sram_blockAddr, sram_victimBlockAddr, mem_addr;
  logic [BITS-1:0] sram_dataIn, sram_dataOut, mem_wdata, mem_rdata;
  logic sram_hit, sram_dirtyBit, mem_req, mem_we, mem_ready;
  logic [31:0] perf_hits, perf_misses, perf_wbs;

  int tests = 0, fails = 0;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
    .sram_bytesAccess(sram_bytesAccess), .sram_blockAddr(sram_blockAddr), .sram_dataIn(sram_dataIn),
    .sram_hit(sram_hit), .sram_dirtyBit(sram_dirtyBit), .sram_dataOut(sram_dataOut),
    .sram_victimBlockAddr(sram_victimBlockAddr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] mem_block(input logic [BA_W-1:0] ba);
    logic [BITS-1:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = 32'hA000_0000 | (32'(ba[11:0]) << 8) | 32'(i);
    return b;
  endfunction

  // One-entry SRAM model
  logic m_valid = 0, m_dirty = 0;
  logic [BA_W-1:0] m_tag = 0;
  logic [BITS-1:0] m_data = 0;
  logic pre_go = 0, pre_valid = 0, pre_dirty = 0;
  logic [BA_W-1:0] pre_tag = 0;
  logic [BITS-1:0] pre_data = 0;

  assign sram_hit             = m_valid && (m_tag == sram_blockAddr);
  assign sram_dirtyBit        = m_valid && m_dirty;
  assign sram_dataOut         = m_data;
  assign sram_victimBlockAddr = m_tag;

  always @(posedge clk) begin
    if (pre_go) begin
      m_valid <= pre_valid; m_dirty <= pre_dirty; m_tag <= pre_tag; m_data <= pre_data;
    end else if (sram_memWen) begin
      m_valid <= 1'b1; m_dirty <= 1'b0; m_tag <= sram_blockAddr; m_data <= sram_dataIn;
    end else if (sram_wen && sram_hit) begin
      m_dirty <= 1'b1;
      for (int b = 0; b < BB; b++)
        if (sram_bytesAccess[b]) m_data[8*b +: 8] <= sram_dataIn[8*b +: 8];
    end
  end

  // Memory responder: mem_ready in the lat-th cycle of each request
  int lwb = 2, lfill = 3, resp_cnt = 0;
  logic mem_en = 1, resp_ready = 0, force_ready = 0;
  assign mem_ready = resp_ready | force_ready;
  assign mem_rdata = mem_block(mem_addr);

  always @(posedge clk) begin
    #1;
    if (!mem_en || !mem_req) begin
      resp_ready = 0; resp_cnt = 0;
    end else if (resp_cnt >= (mem_we ? lwb : lfill) - 1) begin
      resp_ready = 1; resp_cnt = 0;
    end else begin
      resp_ready = 0; resp_cnt++;
    end
  end

  // Monotonic monitors; tests take differences
  int req_cyc = 0, fill_cyc = 0, memwen_cyc = 0, wb_cnt = 0;
  logic [BA_W-1:0] fill_addr = 0, wb_addr = 0;
  logic [BITS-1:0] wb_data = 0;
  always @(negedge clk) begin
    if (mem_req) req_cyc++;
    if (mem_req && !mem_we) begin fill_cyc++; fill_addr = mem_addr; end
    if (sram_memWen) memwen_cyc++;
    if (mem_req && mem_we && mem_ready) begin wb_cnt++; wb_addr = mem_addr; wb_data = mem_wdata; end
  end

  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic v, input logic d, input logic [BA_W-1:0] t, input logic [BITS-1:0] data);
    pre_valid = v; pre_dirty = d; pre_tag = t; pre_data = data; pre_go = 1;
    @(posedge clk); #1;
    pre_go = 0;
  endtask

  // Called just after a rising edge; returns just after the edge that commits the access.
  task automatic access(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls, output logic [31:0] rd,
                        output logic s_wen, output logic [BB-1:0] s_ba);
    logic done = 0;
    cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wd; cpu_byteen = be;
    stalls = 0; rd = 0; s_wen = 0; s_ba = 0;
    while (!done && stalls < 60) begin
      @(negedge clk);
      if (!cpu_stall) begin
        rd = cpu_rdata; s_wen = sram_wen; s_ba = sram_bytesAccess; done = 1;
      end else stalls++;
      @(posedge clk); #1;
    end
    check("access_timeout", done, 1'b1);
    cpu_ren = 0; cpu_wen = 0;
    $display("[TB] access ren=%0b wen=%0b addr=%0h stalls=%0d rdata=%0h", ren, wen, addr, stalls, rd);
  endtask

  int st, r0, f0, m0, w0, waited;
  logic [31:0] rd;
  logic sw;
  logic [BB-1:0] sba;
  logic [BITS-1:0] blk, victim;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_memwen", sram_memWen, 1'b0);
    check("rst_perf", {perf_hits, perf_misses, perf_wbs}, 96'd0);
    @(posedge clk); #1;

    // Hits on block 2
    for (int i = 0; i < 8; i++) blk[32*i +: 32] = 32'h1111_1111 * (i + 1);
    blk[31:0] = 32'hDEADBEEF;
    preload(1, 0, 27'h2, blk);
    r0 = req_cyc;
    access(1, 0, 32'h40, 0, 0, st, rd, sw, sba);
    check("ldhit_rdata", rd, 32'hDEADBEEF);
    check("ldhit_stall", st, 0);
    access(0, 1, 32'h44, 32'h1234, 4'b0011, st, rd, sw, sba);
    check("sthit_wen", sw, 1'b1);
    check("sthit_bytes", sba, 32'h30);
    check("sthit_stall", st, 0);
    access(1, 0, 32'h44, 0, 0, st, rd, sw, sba);
    check("sthit_commit", rd, 32'h2222_1234);
    check("hits_no_memreq", req_cyc - r0, 0);

    // Clean load miss, L=3
    preload(0, 0, 27'h0, '0);
    lfill = 3; f0 = fill_cyc; m0 = memwen_cyc; w0 = wb_cnt;
    access(1, 0, 32'h40, 0, 0, st, rd, sw, sba);
    check("clean_stall", st, 5);
    check("clean_rdata", rd, 32'hA000_0200);
    check("clean_fill_cycles", fill_cyc - f0, 3);
    check("clean_fill_addr", fill_addr, 27'h2);
    check("clean_memwen", memwen_cyc - m0, 1);
    check("clean_no_wb", wb_cnt - w0, 0);
    check("perf_hits4", perf_hits, PERF ? 32'd4 : 32'd0);
    check("perf_misses1", perf_misses, PERF ? 32'd1 : 32'd0);
    check("perf_wbs0", perf_wbs, 32'd0);

    // Dirty store miss, Lwb=2, Lfill=3
    for (int i = 0; i < 8; i++) victim[32*i +: 32] = 32'hD1D1_0000 + i;
    preload(1, 1, 27'h7, victim);
    lwb = 2; lfill = 3; f0 = fill_cyc; w0 = wb_cnt;
    access(0, 1, 32'h48, 32'hCAFEF00D, 4'b1111, st, rd, sw, sba);
    check("dirty_stall", st, 7);
    check("dirty_wb_count", wb_cnt - w0, 1);
    check("dirty_wb_addr", wb_addr, 27'h7);
    check("dirty_wb_data", wb_data, victim);
    check("dirty_fill_cycles", fill_cyc - f0, 3);
    check("dirty_fill_addr", fill_addr, 27'h2);
    check("dirty_store_word", m_data[95:64], 32'hCAFEF00D);
    check("dirty_word0", m_data[31:0], 32'hA000_0200);
    check("dirty_model_state", {m_tag, m_dirty}, {27'h2, 1'b1});
    check("perf_wbs1", perf_wbs, PERF ? 32'd1 : 32'd0);
    check("perf_misses2", perf_misses, PERF ? 32'd2 : 32'd0);

    // Reset during FILL
    preload(0, 0, 27'h0, '0);
    lfill = 10;
    cpu_ren = 1; cpu_addr = 32'h40;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!(mem_req && !mem_we) && waited < 20);
    check("rst_reach_fill", mem_req && !mem_we, 1'b1);
    @(posedge clk); #1 rst = 1; cpu_ren = 0;
    @(posedge clk); #1 rst = 0; mem_en = 0;
    @(negedge clk);
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_stall", cpu_stall, 1'b0);
    check("midrst_perf", {perf_hits, perf_misses, perf_wbs}, 96'd0);
    @(posedge clk); #1 force_ready = 1;
    @(posedge clk); #1 force_ready = 0;
    m0 = memwen_cyc; r0 = req_cyc;
    repeat (3) @(negedge clk);
    check("stray_ready_memwen", memwen_cyc - m0, 0);
    check("stray_ready_req", req_cyc - r0, 0);
    $display("[TB] reset during FILL, stray mem_ready ignored");
    @(posedge clk); #1 mem_en = 1;

    // Clean miss with L=1 after reset
    lfill = 1;
    access(1, 0, 32'h5C, 0, 0, st, rd, sw, sba);
    check("l1_stall", st, 3);
    check("l1_rdata", rd, 32'hA000_0207);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
